// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants for the two-digit seven-segment display.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
// ---------------------------------------------------------------------------
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Which of the two multiplexed digits is being driven.
    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_sel_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to seven-segment decoder.
//   value [3:0] in  : BCD digit; 10..15 decode to a dash
//   blank       in  : force all segments off (ignored for values above 9)
//   seg   [6:0] out : active-high segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: every path through this block assigns seg, starting with a
    // default, so no latch is inferred.
    always_comb begin
        seg = SEG_DASH;
        if (value <= 4'd9) begin
            if (blank) begin
                seg = SEG_BLANK;
            end else begin
                case (value)
                    4'd0:    seg = SEG_0;
                    4'd1:    seg = SEG_1;
                    4'd2:    seg = SEG_2;
                    4'd3:    seg = SEG_3;
                    4'd4:    seg = SEG_4;
                    4'd5:    seg = SEG_5;
                    4'd6:    seg = SEG_6;
                    4'd7:    seg = SEG_7;
                    4'd8:    seg = SEG_8;
                    4'd9:    seg = SEG_9;
                    default: seg = SEG_DASH;
                endcase
            end
        end
    end

endmodule

// File: rtl/digit_display.sv
// ---------------------------------------------------------------------------
// digit_display
// Two-digit multiplexed seven-segment driver. Latches a BCD tens/units pair
// on a load strobe and alternates between the digits every REFRESH_DIV
// clocks. Overflowed values (any digit above 9) show dashes on both digits;
// a zero tens digit can optionally be blanked.
//   clk            in  : clock
//   reset          in  : synchronous, active-high reset
//   load           in  : one-cycle strobe capturing tens/units
//   tens     [3:0] in  : BCD tens (10..15 means overflow)
//   units    [3:0] in  : BCD units
//   segments [6:0] out : registered segments {g,f,e,d,c,b,a}
//   digit          out : registered digit select, 0 = units, 1 = tens
// ---------------------------------------------------------------------------
module digit_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 6000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] segments,
    output logic       digit
);

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_sel_e       digit_q, digit_d;
    logic [6:0]       segments_q, segments_d;

    logic             wrap;
    logic             overflow;
    logic [3:0]       dec_value;
    logic             dec_blank;

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        digit_d = digit_q;
        if (wrap) begin
            digit_d = (digit_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
        end

        tens_d  = load ? tens  : tens_q;
        units_d = load ? units : units_q;

        // The decode looks ahead to the digit selected on this same edge, but
        // uses the currently latched value, so a load shows one clock later.
        overflow  = (tens_q > 4'd9) || (units_q > 4'd9);
        dec_value = overflow ? 4'hF
                             : ((digit_d == DIG_TENS) ? tens_q : units_q);
        dec_blank = BLANK_LEADING && (digit_d == DIG_TENS) &&
                    (tens_q == 4'd0) && !overflow;
    end

    bcd_to_7seg u_dec (
        .value (dec_value),
        .blank (dec_blank),
        .seg   (segments_d)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q     <= 4'd0;
            units_q    <= 4'd0;
            cnt_q      <= '0;
            digit_q    <= DIG_UNITS;
            segments_q <= SEG_0;
        end else begin
            tens_q     <= tens_d;
            units_q    <= units_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            segments_q <= segments_d;
        end
    end

    assign segments = segments_q;
    assign digit    = digit_q;

endmodule

// File: tb/tb_digit_display.sv
// ---------------------------------------------------------------------------
// tb_digit_display
// Two DUT instances (leading-zero blanking on and off) share one stimulus
// stream. A reference model predicts both outputs for every clock edge and
// queues them; a monitor pops and compares one entry per edge.
// ---------------------------------------------------------------------------
module tb_digit_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] units = 4'd0;

    logic [6:0] seg_b, seg_n;
    logic       dig_b, dig_n;

    int n_checks = 0;
    int n_fails  = 0;
    bit stim_done = 1'b0;

    typedef struct {
        logic [6:0] seg_b;
        logic [6:0] seg_n;
        logic       dig;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    digit_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .tens     (tens),
        .units    (units),
        .segments (seg_b),
        .digit    (dig_b)
    );

    digit_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) dut_n (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .tens     (tens),
        .units    (units),
        .segments (seg_n),
        .digit    (dig_n)
    );

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // What a display with the given digits shows on one digit position.
    function automatic logic [6:0] show(input int sel, input int t, input int u,
                                        input bit blank_zero);
        logic [6:0] font [10];
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (t > 9 || u > 9) return 7'h40;
        if (sel == 1 && blank_zero && t == 0) return 7'h00;
        return (sel == 1) ? font[t] : font[u];
    endfunction

    // Reference model: the selected digit depends only on how many edges
    // have passed since the last reset edge; segments reflect the values
    // held before the current edge.
    initial begin
        int   k;
        int   t_m;
        int   u_m;
        int   sel;
        exp_t e;
        k = 0; t_m = 0; u_m = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                k = 0; t_m = 0; u_m = 0;
                e.seg_b = 7'h3F; e.seg_n = 7'h3F; e.dig = 1'b0;
            end else begin
                k++;
                sel = (k / DIV) % 2;
                e.dig   = (sel == 1);
                e.seg_b = show(sel, t_m, u_m, 1'b1);
                e.seg_n = show(sel, t_m, u_m, 1'b0);
                if (load) begin
                    t_m = int'(tens);
                    u_m = int'(units);
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare one queued prediction per edge, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_blank",   {1'b0, seg_b}, {1'b0, e.seg_b});
                check("seg_noblank", {1'b0, seg_n}, {1'b0, e.seg_n});
                check("digit_blank",   {7'd0, dig_b}, {7'd0, e.dig});
                check("digit_noblank", {7'd0, dig_n}, {7'd0, e.dig});
            end
        end
    end

    // Inputs change on the falling edge and are seen on the next rising edge.
    task automatic drive(input bit r, input bit l, input int t, input int u);
        @(negedge clk);
        reset = r;
        load  = l;
        tens  = 4'(t);
        units = 4'(u);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    initial begin
        // Reset, then watch the blanked tens digit appear after DIV clocks.
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        idle(10);

        // 4/2 across several dwells.
        drive(1, 0, 0, 0);
        drive(0, 1, 4, 2);
        idle(12);

        // Overflow, then a zero tens digit.
        drive(0, 1, 12, 7);
        idle(8);
        drive(0, 1, 0, 5);
        idle(8);

        // Load landing exactly on the wrap edge (4th edge after reset).
        drive(1, 0, 0, 0);
        idle(3);
        drive(0, 1, 3, 9);
        idle(6);

        // Reset while the counter holds 2, with 8/8 latched.
        drive(1, 0, 0, 0);
        drive(0, 1, 8, 8);
        idle(1);
        drive(1, 0, 0, 0);
        idle(10);

        // All zeros: units 3F on both, tens 00 vs 3F.
        drive(0, 1, 0, 0);
        idle(10);

        // Back-to-back loads; the last one sticks.
        drive(0, 1, 6, 1);
        drive(0, 1, 7, 3);
        idle(9);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            int l;
            int t;
            int u;
            r = ($urandom_range(99) < 2) ? 1 : 0;
            l = ($urandom_range(99) < 25) ? 1 : 0;
            t = ($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(9);
            u = ($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(9);
            drive(r[0], l[0], t, u);
        end
        idle(4);
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (!stim_done) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", guard);
        end
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/digit_display.md
DIGIT_DISPLAY -- requirements
Module: digit_display

Interface
REQ-001 Parameter REFRESH_DIV, default 6000, SHALL set the clocks per digit dwell (1 kHz per digit at 12 MHz); legal range is 2..65535.
REQ-002 Parameter BLANK_LEADING, default 1, SHALL set tens-digit blanking: 1 blanks a zero tens digit, 0 shows it.
REQ-003 clk  input  1  clock for all state; reset is sampled on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  single-cycle strobe; when high, tens and units are valid and SHALL be captured.
REQ-006 tens  input  4  BCD tens value from the frequency counter; values 10..15 are possible (overflow).
REQ-007 units  input  4  BCD units value.
REQ-008 segments  output  7  active-high segments {g,f,e,d,c,b,a}, registered.
REQ-009 digit  output  1  selected digit, registered: 0 = units, 1 = tens.

Function
REQ-010 Capture: load=1 at edge N SHALL update tens_q/units_q at N; load=0 SHALL hold them indefinitely.
REQ-011 Refresh counter SHALL count 0..REFRESH_DIV-1 every clock, then wrap to 0.
REQ-012 At the wrap edge, digit SHALL toggle; dwell per digit is exactly REFRESH_DIV clocks.
REQ-013 Each clock, segments SHALL be loaded with the decode of the latched value of the digit that digit takes on that same edge, so segments and digit never disagree.
REQ-014 Latency: a value loaded at edge N SHALL appear on segments at edge N+1 if its digit is selected; otherwise at the next toggle.
REQ-015 Decode (hex) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-016 Overflow: if tens_q>9 or units_q>9, both digits SHALL show dash 7'h40.
REQ-017 Blanking: with BLANK_LEADING=1, tens_q==0 and no overflow, the tens digit SHALL output 7'h00; the units digit is never blanked.
REQ-018 load coincident with a digit toggle SHALL perform both; the newly selected digit SHALL show the new value at the next edge.
REQ-019 Back-to-back load pulses SHALL each be captured; the last one wins.
REQ-020 Refresh cadence SHALL be independent of load activity.

Reset
REQ-021 reset SHALL have priority over load and the refresh counter.
REQ-022 During reset the block SHALL set: tens_q=0, units_q=0, counter=0, digit=0, segments=7'h3F.
REQ-023 Asserting reset mid-dwell SHALL restart the dwell; the first toggle SHALL occur REFRESH_DIV clocks after reset deasserts.
REQ-024 No output SHALL be X after the first reset edge.

Structure
REQ-025 Package display_pkg SHALL hold the segment constants: SEG_0..SEG_9, SEG_DASH=7'h40, SEG_BLANK=7'h00.
REQ-026 The counter width SHALL be $clog2(REFRESH_DIV), defined locally.
REQ-027 One combinational sub-module, bcd_to_7seg, SHALL be used:
- inputs: value[3:0], blank;
- output: seg[6:0];
- returns SEG_DASH for value>9.
REQ-028 All flops SHALL be in clk domain, with no latches and no gated clocks.

Verification (bench uses REFRESH_DIV=4)
REQ-029 Reset with BLANK_LEADING=1 -> digit=0, segments=3F; toggles to digit=1, segments=00 after 4 clocks.
REQ-030 load with tens=4, units=2 -> units dwell shows 5B; tens dwell shows 66; each dwell lasts 4 clocks.
REQ-031 load with tens=12, units=7 -> both digits show 40; then load with tens=0, units=5 -> units 6D, tens 00.
REQ-032 load with tens=3, units=9 on the wrap edge -> digit toggles to 1, and the next edge shows segments=4F.
REQ-033 Reset asserted at counter=2 with value 8/8 loaded -> segments=3F, digit=0, and the next toggle comes 4 clocks after release.
REQ-034 BLANK_LEADING=0, load with tens=0, units=0 -> both digits show 3F.
